wb_cmd_initiator: RTL and testbench
===================================

Name: wb_cmd_initiator

Overview:
Wishbone classic (B3, non-pipelined) bus initiator that drives the wishbone slave port of a user project macro inside the user project wrapper. It takes single read/write commands over a valid/ready command channel and runs one Wishbone cycle per command. It returns read data or a timeout error on a valid/ready response channel. The block is used as a self-test/bring-up master and as the bench-side driver for user project slaves.

Parameters:
TIMEOUT_CYCLES, 255, maximum number of cycles stb may stay high without ack; 0 disables the timeout.
ERR_CNT_W, 8, width of the saturating timeout counter.

Ports:
wb_clk_i  input  1  clock; all logic on the rising edge.
wb_rst_i  input  1  reset, synchronous, active-high.
cmd_valid  input  1  command present.
cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
cmd_we  input  1  1 = write, 0 = read.
cmd_adr  input  32  byte address.
cmd_dat  input  32  write data.
cmd_sel  input  4  byte lane selects.
rsp_valid  output  1  response present.
rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high.
rsp_dat  output  32  read data; 0 for writes and for timeouts.
rsp_err  output  1  1 = transaction timed out.
err_count  output  ERR_CNT_W  saturating count of timeouts since reset.
wbm_cyc_o  output  1  Wishbone cycle.
wbm_stb_o  output  1  Wishbone strobe.
wbm_we_o  output  1  Wishbone write enable.
wbm_adr_o  output  32  Wishbone address.
wbm_dat_o  output  32  Wishbone write data.
wbm_sel_o  output  4  Wishbone byte selects.
wbm_dat_i  input  32  Wishbone read data.
wbm_ack_i  input  1  Wishbone acknowledge.

Behaviour:
- Reset values: all outputs are 0, including cmd_ready. State is IDLE and the timeout counter is 0.
- FSM states: IDLE, BUS, RESP. All outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - On handshake, latch we/adr/dat/sel into wbm_* and clear the timeout counter.
  - On the next edge, wbm_cyc_o = wbm_stb_o = 1, cmd_ready = 0, and the state goes to BUS.
- BUS:
  - wbm_* are held stable.
  - On any edge where wbm_ack_i = 1:
    - clear cyc and stb;
    - rsp_dat = wbm_dat_i for a read, 0 for a write;
    - rsp_err = 0, rsp_valid = 1;
    - go to RESP.
  - If there is no ack and TIMEOUT_CYCLES != 0, the counter increments.
  - When the counter reaches TIMEOUT_CYCLES (stb has been high for TIMEOUT_CYCLES edges with no ack):
    - clear cyc and stb;
    - rsp_err = 1, rsp_dat = 0, rsp_valid = 1;
    - err_count increments, saturating at all-ones;
    - go to RESP.
  - If ack arrives on the same edge the timeout would fire, ack wins and no error is reported.
- RESP:
  - rsp_valid, rsp_dat and rsp_err are held until rsp_ready.
  - On handshake, rsp_valid = 0, cmd_ready = 1 and the state goes to IDLE.
  - A new command is not accepted on the same edge as the response handshake.
- Minimum latency for a zero-wait-state slave:
  - cmd accept at edge N;
  - stb high during cycle N+1, ack sampled at edge N+1;
  - rsp_valid high from N+1;
  - with rsp_ready held high, the response handshakes at N+2;
  - cmd_ready is high from N+2, so the next accept is at N+3 at the earliest.
- wbm_ack_i outside BUS is ignored; no state or output changes.
- wbm_adr_o, wbm_dat_o, wbm_sel_o and wbm_we_o keep their last values after the cycle ends. They are only meaningful while cyc is high.
- Counter width is clog2(TIMEOUT_CYCLES+1), minimum 1 bit.
- Reset mid-transaction: at the reset edge, cyc, stb and rsp_valid drop to 0 and any pending response is discarded. err_count is cleared.

Test Plan:
1. Zero-wait write: cmd_we=1, adr=0x3000_0004, dat=0xDEADBEEF, sel=0xF; slave acks in the first stb cycle -> wbm_* carry those values with cyc/stb high exactly 1 cycle; rsp_valid next edge with rsp_err=0, rsp_dat=0.
2. Read with 3 wait states: slave acks on the 4th stb cycle with dat_i=0x1234_5678 -> cyc/stb high 4 cycles; rsp_dat=0x12345678, rsp_err=0.
3. Timeout: TIMEOUT_CYCLES=4, no ack -> stb high exactly 4 cycles then drops; rsp_err=1, rsp_dat=0, err_count=1. Then ack with TIMEOUT_CYCLES=4 on the 4th cycle -> rsp_err=0, err_count unchanged.
4. Response backpressure: rsp_ready low for 5 cycles -> rsp_valid/rsp_dat stable, cmd_ready=0 throughout, cmd_valid ignored; after the handshake, cmd_ready=1.
5. Reset during BUS (2nd wait cycle) -> next edge cyc=stb=rsp_valid=err_count=0, cmd_ready=0; cmd_ready=1 after reset deasserts. A stray ack in IDLE produces no response.
6. Saturation: ERR_CNT_W=2, 5 consecutive timeouts -> err_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/wb_cmd_initiator_if.sv
// wb_cmd_initiator_if: command, response and Wishbone signals of the initiator
interface wb_cmd_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_dat_i, wbm_ack_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_dat_i, wbm_ack_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );
endinterface

// File: rtl/wb_cmd_initiator.sv
// wb_cmd_initiator: one Wishbone classic cycle per command, read data or timeout on the response channel
module wb_cmd_initiator #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wb_cmd_initiator_if.master   bus,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          cnt_q, cnt_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [31:0]            rsp_dat_q, rsp_dat_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   cyc_q, cyc_d;
    logic                   stb_q, stb_d;
    logic                   we_q, we_d;
    logic [31:0]            adr_q, adr_d;
    logic [31:0]            dat_q, dat_d;
    logic [3:0]             sel_q, sel_d;

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = stb_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign bus.wbm_sel_o = sel_q;
    assign err_count     = err_count_q;

    // State and registered outputs; reset drops any cycle in flight and discards a pending response
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_count_q <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_count_q <= err_count_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
        end
    end

    // Next state: accept a command, run the bus cycle until ack or timeout (ack wins a tie), hold the response
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_count_d = err_count_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        case (state_q)
            IDLE: begin
                if (cmd_ready_q && bus.cmd_valid) begin
                    we_d        = bus.cmd_we;
                    adr_d       = bus.cmd_adr;
                    dat_d       = bus.cmd_dat;
                    sel_d       = bus.cmd_sel;
                    cnt_d       = '0;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = BUS;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            BUS: begin
                if (bus.wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_dat_d   = we_q ? '0 : bus.wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == T_LAST) begin
                        cyc_d       = 1'b0;
                        stb_d       = 1'b0;
                        rsp_dat_d   = '0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        err_count_d = (&err_count_q) ? err_count_q : err_count_q + 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_wb_cmd_initiator.sv
// tb_wb_cmd_initiator: directed test of wb_cmd_initiator with TIMEOUT_CYCLES=4, ERR_CNT_W=2
module tb_wb_cmd_initiator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] err_count;
    int         passed = 0;
    int         total = 0;

    wb_cmd_initiator_if b ();

    wb_cmd_initiator #(.TIMEOUT_CYCLES(4), .ERR_CNT_W(2)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (b.master),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        b.cmd_valid = 1'b1;
        b.cmd_we    = we;
        b.cmd_adr   = adr;
        b.cmd_dat   = dat;
        b.cmd_sel   = sel;
    endtask

    initial begin
        b.cmd_valid = 0; b.cmd_we = 0; b.cmd_adr = 0; b.cmd_dat = 0; b.cmd_sel = 0;
        b.rsp_ready = 0; b.wbm_dat_i = 0; b.wbm_ack_i = 0;
        step(2);
        check("rst_cmd_ready", 32'(b.cmd_ready), 0);
        check("rst_cyc", 32'(b.wbm_cyc_o), 0);
        check("rst_stb", 32'(b.wbm_stb_o), 0);
        check("rst_rsp_valid", 32'(b.rsp_valid), 0);
        check("rst_adr", b.wbm_adr_o, 0);
        check("rst_err_count", 32'(err_count), 0);
        rst = 0;
        step(1);
        check("ready_after_rst", 32'(b.cmd_ready), 1);

        // zero-wait write
        send(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        step(1);
        b.cmd_valid = 0;
        check("w_cyc", 32'(b.wbm_cyc_o), 1);
        check("w_stb", 32'(b.wbm_stb_o), 1);
        check("w_we", 32'(b.wbm_we_o), 1);
        check("w_adr", b.wbm_adr_o, 32'h3000_0004);
        check("w_dat", b.wbm_dat_o, 32'hDEAD_BEEF);
        check("w_sel", 32'(b.wbm_sel_o), 32'hF);
        check("w_cmd_ready_low", 32'(b.cmd_ready), 0);
        b.wbm_ack_i = 1; b.wbm_dat_i = 32'hFFFF_FFFF;
        step(1);
        b.wbm_ack_i = 0;
        check("w_cyc_drop", 32'(b.wbm_cyc_o), 0);
        check("w_stb_drop", 32'(b.wbm_stb_o), 0);
        check("w_rsp_valid", 32'(b.rsp_valid), 1);
        check("w_rsp_err", 32'(b.rsp_err), 0);
        check("w_rsp_dat", b.rsp_dat, 0);
        b.rsp_ready = 1;
        step(1);
        b.rsp_ready = 0;
        check("w_rsp_done", 32'(b.rsp_valid), 0);
        check("w_ready_again", 32'(b.cmd_ready), 1);

        // read with 3 wait states, ack on the edge the timeout would fire
        send(1'b0, 32'h3000_0010, 32'h0, 4'h3);
        step(1);
        b.cmd_valid = 0;
        check("r_cyc", 32'(b.wbm_cyc_o), 1);
        check("r_we", 32'(b.wbm_we_o), 0);
        check("r_sel", 32'(b.wbm_sel_o), 32'h3);
        step(3);
        check("r_stb_wait3", 32'(b.wbm_stb_o), 1);
        check("r_no_rsp_yet", 32'(b.rsp_valid), 0);
        b.wbm_ack_i = 1; b.wbm_dat_i = 32'h1234_5678;
        step(1);
        b.wbm_ack_i = 0; b.wbm_dat_i = 32'h0BAD_0BAD;
        check("r_stb_drop", 32'(b.wbm_stb_o), 0);
        check("r_rsp_valid", 32'(b.rsp_valid), 1);
        check("r_rsp_dat", b.rsp_dat, 32'h1234_5678);
        check("r_rsp_err", 32'(b.rsp_err), 0);
        check("r_err_count", 32'(err_count), 0);

        // response backpressure with a command waiting
        send(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("bp_rsp_valid", 32'(b.rsp_valid), 1);
            check("bp_rsp_dat", b.rsp_dat, 32'h1234_5678);
            check("bp_cmd_ready", 32'(b.cmd_ready), 0);
            check("bp_cyc", 32'(b.wbm_cyc_o), 0);
        end
        b.rsp_ready = 1;
        step(1);
        b.rsp_ready = 0;
        check("bp_rsp_done", 32'(b.rsp_valid), 0);
        check("bp_ready", 32'(b.cmd_ready), 1);
        check("bp_no_same_edge_accept", 32'(b.wbm_cyc_o), 0);

        // timeout: the waiting read is accepted now, no ack
        b.wbm_dat_i = 32'hCAFE_F00D;
        step(1);
        b.cmd_valid = 0;
        check("to_cyc", 32'(b.wbm_cyc_o), 1);
        check("to_adr", b.wbm_adr_o, 32'h3000_0020);
        step(3);
        check("to_stb_still", 32'(b.wbm_stb_o), 1);
        step(1);
        check("to_stb_drop", 32'(b.wbm_stb_o), 0);
        check("to_cyc_drop", 32'(b.wbm_cyc_o), 0);
        check("to_rsp_valid", 32'(b.rsp_valid), 1);
        check("to_rsp_err", 32'(b.rsp_err), 1);
        check("to_rsp_dat", b.rsp_dat, 0);
        check("to_err_count", 32'(err_count), 1);
        b.rsp_ready = 1;
        step(1);
        b.rsp_ready = 0;

        // ack on the 4th stb cycle with the timeout armed
        send(1'b0, 32'h3000_0024, 32'h0, 4'hF);
        step(1);
        b.cmd_valid = 0;
        step(3);
        b.wbm_ack_i = 1; b.wbm_dat_i = 32'hA5A5_5A5A;
        step(1);
        b.wbm_ack_i = 0;
        check("tie_rsp_err", 32'(b.rsp_err), 0);
        check("tie_rsp_dat", b.rsp_dat, 32'hA5A5_5A5A);
        check("tie_err_count", 32'(err_count), 1);
        b.rsp_ready = 1;
        step(1);
        b.rsp_ready = 0;

        // reset in the 2nd wait cycle of a bus cycle
        send(1'b1, 32'h3000_0030, 32'h5555_AAAA, 4'hF);
        step(1);
        b.cmd_valid = 0;
        step(1);
        check("mr_in_bus", 32'(b.wbm_stb_o), 1);
        rst = 1;
        step(1);
        check("mr_cyc", 32'(b.wbm_cyc_o), 0);
        check("mr_stb", 32'(b.wbm_stb_o), 0);
        check("mr_rsp_valid", 32'(b.rsp_valid), 0);
        check("mr_err_count", 32'(err_count), 0);
        check("mr_cmd_ready", 32'(b.cmd_ready), 0);
        rst = 0;
        step(1);
        check("mr_ready_after", 32'(b.cmd_ready), 1);
        b.wbm_ack_i = 1;
        step(2);
        b.wbm_ack_i = 0;
        check("stray_ack_rsp", 32'(b.rsp_valid), 0);
        check("stray_ack_cyc", 32'(b.wbm_cyc_o), 0);
        check("stray_ack_ready", 32'(b.cmd_ready), 1);

        // saturation of the 2-bit timeout counter
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 32'h3000_0040, 32'h0, 4'hF);
            step(1);
            b.cmd_valid = 0;
            step(4);
            check("sat_rsp_err", 32'(b.rsp_err), 1);
            check("sat_err_count", 32'(err_count), (i + 1 > 3) ? 3 : i + 1);
            b.rsp_ready = 1;
            step(1);
            b.rsp_ready = 0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
